stopwatch_mux_ctrl: RTL and testbench
=====================================

// Module: stopwatch_mux_ctrl
// PURPOSE
//  Parametrised mm:ss-style stopwatch core: NUM_DIGITS/2 base-60 fields (units 0-9, tens 0-5),
//  run/pause/adjust control, blinking of the field under adjustment, multiplexed 7-seg scan.
//  Single clock domain: all rates come from internal clock-enable dividers, with no derived clocks.
//  Sits between the board pins (buttons, switches, anodes, cathodes) and the top level.
// PARAMETERS
//  NUM_DIGITS  4            digits displayed/counted; even, 2..8; digit 0 = rightmost units
//  TICK_DIV    100_000_000  clk cycles per count tick (1 Hz at 100 MHz)
//  ADJ_DIV     50_000_000   clk cycles per adjust increment (2 Hz)
//  BLINK_DIV   25_000_000   clk cycles per blink phase toggle
//  SCAN_DIV    100_000      clk cycles per anode advance
// PORTS
//  clk         in   1                clock, the only clock
//  rst         in   1                synchronous, active-high reset
//  pause_btn   in   1                raw button; each rising edge toggles pause
//  adj_sw      in   1                raw switch; 1 = adjust mode
//  sel_sw      in   SEL_W            field to adjust; SEL_W = max(1,$clog2(NUM_DIGITS/2)); 0 = digits 1:0
//  an          out  NUM_DIGITS       anodes, active-low, one-hot-low during scan
//  seg         out  7                cathodes {G..A}, active-low
//  digits_bcd  out  4*NUM_DIGITS     live count, digit i at [4i+3:4i]
//  rollover    out  1                1-cycle pulse when the full count wraps to zero
// BEHAVIOUR
//  - Inputs pass through a 2-FF synchronizer; the pause edge comes from a 3rd FF, rise = s[1]&~s[2].
//  - Reset (rst=1 at posedge): an='1, seg=7'h7F, digits_bcd=0, rollover=0, all dividers=0,
//    pause flag=0, scan index=0, blink phase=0, state=CLEAR.
//  - FSM: CLEAR -> RUN unconditionally on the next cycle (digits held 0).
//    RUN: tick divider counts; at TICK_DIV-1 it restarts at 0 and issues 1 increment.
//    PAUSED: all count dividers hold, digits hold, and the display continues scanning.
//    ADJ: ADJ_DIV divider counts from 0 on entry; each wrap increments the selected field only.
//    Transitions are evaluated every cycle. Priority: pause toggle > adj_sw.
//    RUN/ADJ + pause rise -> PAUSED; PAUSED + pause rise -> ADJ if adj_sw else RUN.
//    RUN <-> ADJ follows adj_sw level; the tick divider keeps its value across ADJ.
//  - Increment (RUN): units 9->0 carries to tens; tens 5->0 carries to next field; top field
//    59 wrap -> all digits 0 and rollover=1 in the same cycle the digits update.
//  - Increment (ADJ): the selected field only; 59->00 with no carry out and no rollover.
//    sel_sw >= NUM_DIGITS/2 selects nothing, so adjust increments are dropped.
//  - Blink: in ADJ, both digits of the selected field are blanked (seg=7'h7F) while blink
//    phase=1. The phase toggles every BLINK_DIV cycles and is forced to 0 outside ADJ.
//  - Scan: index advances every SCAN_DIV cycles, wrapping at NUM_DIGITS-1 -> 0. an/seg are
//    registered together and change in the cycle after the index changes, with no ghost cycle.
//  - digits_bcd is registered and valid the cycle after the increment condition.
//  - rst mid-count or mid-ADJ: next cycle matches the reset values exactly.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: adds input lap_btn (1 bit, synchronized and edge-detected like
//    pause_btn). A rise in RUN or PAUSED freezes a lap copy. an/seg then show the copy while
//    counting continues. The next rise releases it. Reset or entering ADJ clears the freeze.
//    digits_bcd always shows the live count.
//  Undefined: no lap_btn port, and the display always shows the live count.
// STRUCTURE
//  stopwatch_pkg: state enum (CLEAR,RUN,PAUSED,ADJ), SEG_BLANK=7'h7F, BCD max
//    constants (UNITS_MAX=9, TENS_MAX=5), seg7 code table.
//  Sub-module seg7_decode: 4-bit BCD + blank -> 7-bit active-low cathodes, combinational.
//  Dividers, synchronizers, FSM, counters and the scan mux stay in this module.
// TESTING (bench uses TICK_DIV=10, ADJ_DIV=4, BLINK_DIV=3, SCAN_DIV=2, NUM_DIGITS=4)
//  - rst 1 cycle -> an=4'hF, seg=7'h7F, digits 0; after 10 RUN cycles digits_bcd=16'h0001.
//  - Preload-by-running to 59:59, 1 more tick -> digits_bcd=16'h0000 and a 1-cycle rollover.
//  - Pause rise at count 00:07 -> held 00:07 for 100 cycles; 2nd rise resumes, 00:08 after
//    the remaining divider cycles.
//  - adj_sw=1, sel_sw=1 at 00:58 -> field 1 increments every 4 cycles (00:58 -> 01:58),
//    digits 1:0 unchanged; field 1 at 59 -> 00 with no rollover.
//  - In ADJ sel_sw=0, check an=4'b1110/4'b1101 phases show seg=7'h7F while blink=1.
//    pause rise and adj_sw fall in the same cycle -> PAUSED.
//  - Scan: an sequence 1110,1101,1011,0111 repeating every 8 cycles; rst mid-ADJ -> reset values.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state encodings, BCD limits and 7-segment code table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR  = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_PAUSED = 2'd2;
  localparam state_t ST_ADJ    = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Even digit positions are units (0-9), odd positions are tens (0-5).
  function automatic logic [3:0] digit_max(input int pos);
    digit_max = (pos % 2 == 0) ? UNITS_MAX : TENS_MAX;
  endfunction

  // Active-low cathodes, bit order {G,F,E,D,C,B,A}.
  function automatic logic [6:0] seg7_code(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg7_code = 7'h40;
      4'd1:    seg7_code = 7'h79;
      4'd2:    seg7_code = 7'h24;
      4'd3:    seg7_code = 7'h30;
      4'd4:    seg7_code = 7'h19;
      4'd5:    seg7_code = 7'h12;
      4'd6:    seg7_code = 7'h02;
      4'd7:    seg7_code = 7'h78;
      4'd8:    seg7_code = 7'h00;
      4'd9:    seg7_code = 7'h10;
      default: seg7_code = SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational BCD to active-low 7-segment decoder with blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg7_code(bcd_i);

endmodule

`default_nettype wire

// File: rtl/stopwatch_mux_ctrl.sv
// ============================================================================
// Module   : stopwatch_mux_ctrl
// Brief    : Base-60 stopwatch core with run/pause/adjust control, blinking
//            adjust field and multiplexed 7-segment scan. Optional lap freeze
//            of the display is enabled by defining STOPWATCH_LAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stopwatch_mux_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int TICK_DIV   = 100_000_000,
  parameter  int ADJ_DIV    = 50_000_000,
  parameter  int BLINK_DIV  = 25_000_000,
  parameter  int SCAN_DIV   = 100_000,
  localparam int NUM_FIELDS = NUM_DIGITS / 2,
  localparam int SEL_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause_btn,
`ifdef STOPWATCH_LAP_EN
  input  logic                    lap_btn,
`endif
  input  logic                    adj_sw,
  input  logic [SEL_W-1:0]        sel_sw,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic                    rollover
);

  localparam int TICK_W  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int ADJ_W   = (ADJ_DIV > 1)    ? $clog2(ADJ_DIV)    : 1;
  localparam int BLINK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [ADJ_W-1:0]   ADJ_LAST   = ADJ_W'(ADJ_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [2:0]              pause_s_q;
  logic [1:0]              adj_s_q;
  logic [SEL_W-1:0]        sel_s1_q, sel_s2_q;
  state_t                  state_q, state_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [ADJ_W-1:0]        adjdiv_q, adjdiv_d;
  logic [BLINK_W-1:0]      blinkcnt_q, blinkcnt_d;
  logic                    blink_q, blink_d;
  logic [SCAN_W-1:0]       scancnt_q, scancnt_d;
  logic [IDX_W-1:0]        scanidx_q, scanidx_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    rollover_q, rollover_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic                    pause_rise, adj_lvl;
  logic                    tick_wrap, adj_wrap, blink_wrap, scan_wrap;
  logic                    carry;
  logic [3:0]              cur_bcd;
  logic                    blank;
  logic [4*NUM_DIGITS-1:0] disp_digits;

  assign pause_rise = pause_s_q[1] & ~pause_s_q[2];
  assign adj_lvl    = adj_s_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:  state_d = ST_RUN;
      ST_RUN: begin
        if (pause_rise)   state_d = ST_PAUSED;
        else if (adj_lvl) state_d = ST_ADJ;
      end
      ST_PAUSED: begin
        if (pause_rise)   state_d = adj_lvl ? ST_ADJ : ST_RUN;
      end
      ST_ADJ: begin
        if (pause_rise)   state_d = ST_PAUSED;
        else if (!adj_lvl) state_d = ST_RUN;
      end
      default:   state_d = ST_CLEAR;
    endcase
  end

  // The tick divider only advances in RUN, so it resumes mid-second after PAUSED/ADJ.
  always_comb begin
    tick_wrap  = (state_q == ST_RUN) && (tick_q == TICK_LAST);
    adj_wrap   = (state_q == ST_ADJ) && (adjdiv_q == ADJ_LAST);
    blink_wrap = (state_q == ST_ADJ) && (blinkcnt_q == BLINK_LAST);
    scan_wrap  = (scancnt_q == SCAN_LAST);

    tick_d = tick_q;
    if (state_q == ST_RUN) tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);

    adjdiv_d   = (state_q == ST_ADJ && !adj_wrap)   ? adjdiv_q + ADJ_W'(1)     : '0;
    blinkcnt_d = (state_q == ST_ADJ && !blink_wrap) ? blinkcnt_q + BLINK_W'(1) : '0;
    blink_d    = (state_q == ST_ADJ) ? (blink_q ^ blink_wrap) : 1'b0;

    scancnt_d = scan_wrap ? '0 : scancnt_q + SCAN_W'(1);
    scanidx_d = scanidx_q;
    if (scan_wrap) scanidx_d = (scanidx_q == IDX_LAST) ? '0 : scanidx_q + IDX_W'(1);
  end

  always_comb begin
    digits_d   = digits_q;
    rollover_d = 1'b0;
    carry      = tick_wrap;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (digits_q[4*i +: 4] == digit_max(i)) begin
          digits_d[4*i +: 4] = 4'd0;
        end else begin
          digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    rollover_d = carry;
    // Adjust wraps the selected field 59 -> 00 without touching neighbours.
    for (int f = 0; f < NUM_FIELDS; f++) begin
      if (adj_wrap && (f == int'(sel_s2_q))) begin
        if (digits_q[8*f +: 4] == UNITS_MAX) begin
          digits_d[8*f +: 4] = 4'd0;
          if (digits_q[8*f+4 +: 4] == TENS_MAX) digits_d[8*f+4 +: 4] = 4'd0;
          else digits_d[8*f+4 +: 4] = digits_q[8*f+4 +: 4] + 4'd1;
        end else begin
          digits_d[8*f +: 4] = digits_q[8*f +: 4] + 4'd1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [2:0]              lap_s_q;
  logic                    lap_rise;
  logic                    lapfrz_q, lapfrz_d;
  logic [4*NUM_DIGITS-1:0] lap_q, lap_d;

  assign lap_rise = lap_s_q[1] & ~lap_s_q[2];

  always_comb begin
    lapfrz_d = lapfrz_q;
    lap_d    = lap_q;
    if (state_d == ST_ADJ) begin
      lapfrz_d = 1'b0;
    end else if (lap_rise && (state_q == ST_RUN || state_q == ST_PAUSED)) begin
      lapfrz_d = ~lapfrz_q;
      if (!lapfrz_q) lap_d = digits_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_s_q  <= '0;
      lapfrz_q <= 1'b0;
      lap_q    <= '0;
    end else begin
      lap_s_q  <= {lap_s_q[1:0], lap_btn};
      lapfrz_q <= lapfrz_d;
      lap_q    <= lap_d;
    end
  end

  assign disp_digits = lapfrz_q ? lap_q : digits_q;
`else
  assign disp_digits = digits_q;
`endif

  always_comb begin
    cur_bcd = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(scanidx_q)) cur_bcd = disp_digits[4*i +: 4];
    end
    blank = (state_q == ST_ADJ) && blink_q &&
            ((int'(scanidx_q) / 2) == int'(sel_s2_q));
    an_d  = ~(NUM_DIGITS'(1) << scanidx_q);
  end

  seg7_decode u_seg7 (
    .bcd_i   (cur_bcd),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_s_q  <= '0;
      adj_s_q    <= '0;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      state_q    <= ST_CLEAR;
      tick_q     <= '0;
      adjdiv_q   <= '0;
      blinkcnt_q <= '0;
      blink_q    <= 1'b0;
      scancnt_q  <= '0;
      scanidx_q  <= '0;
      digits_q   <= '0;
      rollover_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      pause_s_q  <= {pause_s_q[1:0], pause_btn};
      adj_s_q    <= {adj_s_q[0], adj_sw};
      sel_s1_q   <= sel_sw;
      sel_s2_q   <= sel_s1_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      adjdiv_q   <= adjdiv_d;
      blinkcnt_q <= blinkcnt_d;
      blink_q    <= blink_d;
      scancnt_q  <= scancnt_d;
      scanidx_q  <= scanidx_d;
      digits_q   <= digits_d;
      rollover_q <= rollover_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign digits_bcd = digits_q;
  assign rollover   = rollover_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_mux_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_mux_ctrl
// Brief    : Scoreboard bench with a seconds-based reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stopwatch_mux_ctrl;

  localparam int ND = 4, TDIV = 10, ADIV = 4, BDIV = 3, SDIV = 2;
  localparam int M_CLEAR = 0, M_RUN = 1, M_PAUSED = 2, M_ADJ = 3;
  localparam int FULL = 3600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause_btn = 1'b0;
  logic        adj_sw = 1'b0;
  logic        sel_sw = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits_bcd;
  logic        rollover;
`ifdef STOPWATCH_LAP_EN
  logic        lap_btn = 1'b0;
`endif

  stopwatch_mux_ctrl #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TDIV),
    .ADJ_DIV    (ADIV),
    .BLINK_DIV  (BDIV),
    .SCAN_DIV   (SDIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pause_btn  (pause_btn),
`ifdef STOPWATCH_LAP_EN
    .lap_btn    (lap_btn),
`endif
    .adj_sw     (adj_sw),
    .sel_sw     (sel_sw),
    .an         (an),
    .seg        (seg),
    .digits_bcd (digits_bcd),
    .rollover   (rollover)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        roll;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    failures = 0;
  string phase = "init";

  // Reference state: elapsed count held as plain seconds.
  int m_mode, m_total, m_tick, m_adj, m_bcnt, m_blink, m_scnt, m_sidx;
  bit p0, p1, p2, a0, a1, s1, s2;

  function automatic logic [15:0] to_bcd(input int total);
    logic [15:0] r;
    int t, v;
    r = '0;
    t = total;
    for (int f = 0; f < ND / 2; f++) begin
      v = t % 60;
      t = t / 60;
      r[8*f +: 4]   = 4'(v % 10);
      r[8*f+4 +: 4] = 4'(v / 10);
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%s] got=%h expected=%h t=%0t", name, phase, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic [15:0] bcd;
    bit rise, blank, roll;
    int nmode, mult, fv;
    if (rst) begin
      m_mode = M_CLEAR; m_total = 0; m_tick = 0; m_adj = 0; m_bcnt = 0;
      m_blink = 0; m_scnt = 0; m_sidx = 0;
      {p0, p1, p2, a0, a1, s1, s2} = '0;
      e.an = 4'hF; e.seg = 7'h7F; e.digits = 16'h0; e.roll = 1'b0;
    end else begin
      bcd   = to_bcd(m_total);
      blank = (m_mode == M_ADJ) && (m_blink != 0) && ((m_sidx / 2) == int'(s2));
      e.an  = ~(4'b0001 << m_sidx);
      e.seg = blank ? 7'h7F : seg_of(int'(bcd[4*m_sidx +: 4]));
      rise  = p1 & ~p2;
      roll  = 1'b0;
      if (m_mode == M_RUN) begin
        if (m_tick == TDIV - 1) begin
          m_tick = 0;
          roll = (m_total == FULL - 1);
          m_total = (m_total + 1) % FULL;
        end else m_tick++;
      end
      if (m_mode == M_ADJ) begin
        if (m_adj == ADIV - 1) begin
          m_adj = 0;
          if (int'(s2) < ND / 2) begin
            mult = (s2 == 1'b0) ? 1 : 60;
            fv = (m_total / mult) % 60;
            m_total = m_total - fv * mult + ((fv + 1) % 60) * mult;
          end
        end else m_adj++;
        if (m_bcnt == BDIV - 1) begin
          m_bcnt = 0;
          m_blink = 1 - m_blink;
        end else m_bcnt++;
      end else begin
        m_adj = 0; m_bcnt = 0; m_blink = 0;
      end
      if (m_scnt == SDIV - 1) begin
        m_scnt = 0;
        m_sidx = (m_sidx + 1) % ND;
      end else m_scnt++;
      nmode = m_mode;
      case (m_mode)
        M_CLEAR:  nmode = M_RUN;
        M_RUN:    nmode = rise ? M_PAUSED : (a1 ? M_ADJ : M_RUN);
        M_PAUSED: if (rise) nmode = a1 ? M_ADJ : M_RUN;
        default:  nmode = rise ? M_PAUSED : (a1 ? M_ADJ : M_RUN);
      endcase
      m_mode = nmode;
      p2 = p1; p1 = p0; p0 = pause_btn;
      a1 = a0; a0 = adj_sw;
      s2 = s1; s1 = sel_sw;
      e.digits = to_bcd(m_total);
      e.roll   = roll;
    end
    sbq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      e = sbq.pop_front();
      check("an", {12'h0, an}, {12'h0, e.an});
      check("seg", {9'h0, seg}, {9'h0, e.seg});
      check("digits_bcd", digits_bcd, e.digits);
      check("rollover", {15'h0, rollover}, {15'h0, e.roll});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_pause(input int w);
    pause_btn = 1'b1;
    cyc(w);
    pause_btn = 1'b0;
  endtask

  task automatic wait_digits(input logic [15:0] v, input int budget, input string nm);
    int n;
    n = 0;
    while (digits_bcd !== v && n < budget) begin
      cyc(1);
      n++;
    end
    check(nm, digits_bcd, v);
  endtask

  initial begin
    int n, blank_hits, lit_hits, act;

    phase = "reset";
    rst = 1'b1;
    cyc(1);
    check("reset_an", {12'h0, an}, 16'h000F);
    check("reset_seg", {9'h0, seg}, 16'h007F);
    check("reset_digits", digits_bcd, 16'h0000);
    rst = 1'b0;
    cyc(10);
    check("pre_first_tick", digits_bcd, 16'h0000);
    cyc(1);
    check("first_tick", digits_bcd, 16'h0001);

    phase = "rollover";
    wait_digits(16'h5959, 36500, "reach_5959");
    n = 0;
    while (rollover !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    check("rollover_pulse", {15'h0, rollover}, 16'h0001);
    check("rollover_digits", digits_bcd, 16'h0000);
    cyc(1);
    check("rollover_width", {15'h0, rollover}, 16'h0000);

    phase = "pause";
    wait_digits(16'h0007, 100, "reach_0007");
    press_pause(2);
    cyc(100);
    check("pause_hold", digits_bcd, 16'h0007);
    press_pause(1);
    wait_digits(16'h0008, 20, "resume_0008");

    phase = "adjust";
    wait_digits(16'h0058, 600, "reach_0058");
    adj_sw = 1'b1;
    sel_sw = 1'b1;
    wait_digits(16'h0158, 20, "adj_first_step");
    wait_digits(16'h5958, 400, "adj_reach_59");
    wait_digits(16'h0058, 20, "adj_field_wrap");

    phase = "blink";
    sel_sw = 1'b0;
    blank_hits = 0;
    lit_hits = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if ((an == 4'b1110 || an == 4'b1101) && seg == 7'h7F) blank_hits++;
      if ((an == 4'b1110 || an == 4'b1101) && seg != 7'h7F) lit_hits++;
    end
    check("blink_blanked_seen", 16'(blank_hits > 0), 16'd1);
    check("blink_lit_seen", 16'(lit_hits > 0), 16'd1);

    phase = "pause_vs_adj";
    pause_btn = 1'b1;
    adj_sw = 1'b0;
    cyc(2);
    pause_btn = 1'b0;
    cyc(60);
    press_pause(1);
    cyc(40);

    phase = "random";
    for (int i = 0; i < 250; i++) begin
      act = $urandom_range(0, 9);
      case (act)
        0, 1, 2, 3: press_pause($urandom_range(1, 4));
        4, 5:       adj_sw = ~adj_sw;
        6, 7:       sel_sw = 1'($urandom_range(0, 1));
        8: if ($urandom_range(0, 3) == 0) begin
             rst = 1'b1;
             cyc(1);
             rst = 1'b0;
           end
        default: ;
      endcase
      cyc($urandom_range(1, 20));
    end

    phase = "reset_mid_adj";
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    adj_sw = 1'b1;
    sel_sw = 1'b1;
    cyc(25);
    rst = 1'b1;
    cyc(1);
    check("midadj_an", {12'h0, an}, 16'h000F);
    check("midadj_seg", {9'h0, seg}, 16'h007F);
    check("midadj_digits", digits_bcd, 16'h0000);
    check("midadj_rollover", {15'h0, rollover}, 16'h0000);
    rst = 1'b0;
    adj_sw = 1'b0;
    cyc(12);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
